// File: rtl/key_matrix_scan.sv
// 4x8 key matrix scanner: walks an active-low column select, debounces 32 keys and queues events in a 4-deep FIFO.
// Optional feature macro KEY_SCAN_RELEASE_EVT_EN: when defined, release events are queued as well as presses.
module key_matrix_scan #(
  parameter int SCAN_DIV = 32768,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        resx,
  output logic [3:0]  lcol,
  input  logic [7:0]  krow,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [5:0]  key_code,
  output logic [31:0] key_state,
  output logic        overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] PROC_END = DW'(8);
  localparam logic [2:0] DEB = 3'(DEBOUNCE);

  logic [7:0]    krow_meta, krow_sync;
  logic          active;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [7:0]    samp;
  logic [1:0]    pcol;
  logic          proc_vld;
  logic [2:0]    dcnt [32];
  logic [5:0]    fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;

  logic [7:0] rows_s;
  logic       slot_end, proc_on, cur_state, mismatch, hit;
  logic       push_req, pop, full, push_ok, drop;
  logic [2:0] proc_row, cnt_inc;
  logic [4:0] key_idx;
  logic [5:0] evt_code;

  always_comb begin
    rows_s    = ~krow_sync;
    slot_end  = active && (div_cnt == DIV_MAX);
    proc_row  = div_cnt[2:0];
    proc_on   = proc_vld && (div_cnt < PROC_END);
    key_idx   = {pcol, proc_row};
    cur_state = key_state[key_idx];
    cnt_inc   = dcnt[key_idx] + 3'd1;
    mismatch  = samp[proc_row] != cur_state;
    hit       = proc_on && mismatch && (cnt_inc == DEB);
    evt_code  = {~cur_state, pcol, proc_row};
`ifdef KEY_SCAN_RELEASE_EVT_EN
    push_req  = hit;
`else
    push_req  = hit && !cur_state;
`endif
    key_valid = count != 3'd0;
    key_code  = fifo_mem[rd_ptr];
    pop       = key_valid && key_ready;
    full      = count == 3'd4;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    lcol      = active ? ~(4'b0001 << col) : 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (!resx) begin
      krow_meta <= 8'hFF;
      krow_sync <= 8'hFF;
      active    <= 1'b0;
      div_cnt   <= '0;
      col       <= 2'd0;
      samp      <= 8'h00;
      pcol      <= 2'd0;
      proc_vld  <= 1'b0;
      key_state <= 32'h0;
      overflow  <= 1'b0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      for (int i = 0; i < 32; i++) dcnt[i] <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 6'h00;
    end else begin
      krow_meta <= krow;
      krow_sync <= krow_meta;
      active    <= 1'b1;
      if (active) begin
        if (slot_end) begin
          div_cnt  <= '0;
          col      <= col + 2'd1;
          samp     <= rows_s;
          pcol     <= col;
          proc_vld <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (proc_on) begin
        if (!mismatch) begin
          dcnt[key_idx] <= 3'd0;
        end else if (cnt_inc == DEB) begin
          dcnt[key_idx]      <= 3'd0;
          key_state[key_idx] <= ~cur_state;
        end else begin
          dcnt[key_idx] <= cnt_inc;
        end
      end
      if (push_ok) begin
        fifo_mem[wr_ptr] <= evt_code;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (drop) overflow <= 1'b1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: directed key patterns, expected events queued and checked by a monitor.
module tb_key_matrix_scan;

  localparam int SD   = 16;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        resx = 1'b0;
  logic [3:0]  lcol;
  logic [7:0]  krow;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic [5:0]  key_code;
  logic [31:0] key_state;
  logic        overflow;

  logic [31:0] pressed = 32'h0;
  logic [5:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE(2)) dut (
    .clk(clk), .resx(resx), .lcol(lcol), .krow(krow),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_state(key_state), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    krow = 8'hFF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        if (!lcol[c] && pressed[c*8+r]) krow[r] = 1'b0;
  end

  // Scoreboard monitor: every accepted head event is compared to the queue front.
  always @(negedge clk) begin
    if (resx && key_valid && key_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event_unexpected: got %h, none required", key_code);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          bad++;
          $display("FAIL event_code: got %h, required %h", key_code, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lcol(input logic [3:0] v, input int limit);
    int i;
    i = 0;
    while (lcol !== v && i < limit) begin
      cycles(1);
      i++;
    end
    check("wait_lcol", {28'h0, lcol}, {28'h0, v});
  endtask

  task automatic check_reset_vals();
    check("rst_lcol", {28'h0, lcol}, 32'hF);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_code", {26'h0, key_code}, 32'h0);
    check("rst_state", key_state, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
  endtask

  task automatic pulse_reset();
    resx = 1'b0;
    cycles(1);
    check_reset_vals();
    resx = 1'b1;
    cycles(1);
  endtask

  initial begin
    // reset state and column walk
    cycles(3);
    check_reset_vals();
    resx = 1'b1;
    cycles(1);
    check("walk0", {28'h0, lcol}, 32'hE);
    cycles(SD);
    check("walk1", {28'h0, lcol}, 32'hD);
    cycles(SD);
    check("walk2", {28'h0, lcol}, 32'hB);
    cycles(SD);
    check("walk3", {28'h0, lcol}, 32'h7);

    // single press col1 row3, then release
    pressed = 32'h0000_0800;
    exp_q.push_back(6'h2B);
    cycles(3 * SCAN);
    check("press_state", key_state, 32'h0000_0800);
    check("press_drained", exp_q.size(), 0);
    pressed = 32'h0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
    exp_q.push_back(6'h0B);
`endif
    cycles(3 * SCAN);
    check("release_state", key_state, 32'h0);
    check("release_drained", exp_q.size(), 0);

    // two single-scan bounces separated by two matching scans
    pressed = 32'h0000_0800;
    cycles(SCAN);
    pressed = 32'h0;
    cycles(2 * SCAN);
    pressed = 32'h0000_0800;
    cycles(SCAN);
    pressed = 32'h0;
    cycles(3 * SCAN);
    check("bounce_state", key_state, 32'h0);
    check("bounce_valid", {31'h0, key_valid}, 32'h0);

    // overflow: five col0 keys with consumer stalled
    key_ready = 1'b0;
    pressed = 32'h0000_001F;
    exp_q.push_back(6'h20);
    exp_q.push_back(6'h21);
    exp_q.push_back(6'h22);
    exp_q.push_back(6'h23);
    cycles(3 * SCAN);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("ovf_valid", {31'h0, key_valid}, 32'h1);
    check("ovf_head", {26'h0, key_code}, 32'h20);
    check("ovf_state", key_state, 32'h0000_001F);
    key_ready = 1'b1;
    cycles(10);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    check("ovf_empty", {31'h0, key_valid}, 32'h0);
    pressed = 32'h0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
    for (int r = 0; r < 5; r++) exp_q.push_back(6'(r));
`endif
    cycles(3 * SCAN);
    check("ovf_rel_state", key_state, 32'h0);
    check("ovf_rel_drained", exp_q.size(), 0);

    // full FIFO with simultaneous push and pop
    pulse_reset();
    key_ready = 1'b0;
    pressed = 32'h0000_010F;
    exp_q.push_back(6'h20);
    exp_q.push_back(6'h21);
    exp_q.push_back(6'h22);
    exp_q.push_back(6'h23);
    exp_q.push_back(6'h28);
    begin
      int i;
      i = 0;
      while (!key_valid && i < 4 * SCAN) begin
        cycles(1);
        i++;
      end
      check("full_wait_valid", {31'h0, key_valid}, 32'h1);
    end
    wait_lcol(4'hB, SCAN);
    key_ready = 1'b1;
    cycles(1);
    key_ready = 1'b0;
    check("full_ovf_clear", {31'h0, overflow}, 32'h0);
    check("full_head", {26'h0, key_code}, 32'h21);
    cycles(SCAN);
    check("full_still_valid", {31'h0, key_valid}, 32'h1);
    key_ready = 1'b1;
    cycles(10);
    check("full_drained", exp_q.size(), 0);
    check("full_ovf_final", {31'h0, overflow}, 32'h0);
    pressed = 32'h0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
    exp_q.push_back(6'h00);
    exp_q.push_back(6'h01);
    exp_q.push_back(6'h02);
    exp_q.push_back(6'h03);
    exp_q.push_back(6'h08);
`endif
    cycles(3 * SCAN);
    check("full_rel_drained", exp_q.size(), 0);

    // reset mid-processing with a key held, then re-report
    pressed = 32'h0000_0800;
    exp_q.push_back(6'h2B);
    cycles(3 * SCAN);
    check("mid_state", key_state, 32'h0000_0800);
    wait_lcol(4'hB, SCAN);
    pulse_reset();
    exp_q.push_back(6'h2B);
    cycles(3 * SCAN);
    check("rerep_state", key_state, 32'h0000_0800);
    check("rerep_drained", exp_q.size(), 0);
    pressed = 32'h0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
    exp_q.push_back(6'h0B);
`endif
    cycles(3 * SCAN);
    check("final_state", key_state, 32'h0);
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_matrix_scan.md
# key_matrix_scan

Scans a 4-column × 8-row key matrix by walking an active-low column select, the input counterpart of the multiplexed LED column drive. Each of the 32 keys is debounced, and press and release events are queued in a 4-entry FIFO with a valid/ready handshake. The block sits beside the LED matrix driver in the top level and shares the 12 MHz `clk` and the `x`-suffix active-low naming. A debounced 32-bit key bitmap is also exported.

## Interface
- `SCAN_DIV`, default 32768: clock ticks per column slot. Must be ≥ 16.
- `DEBOUNCE`, default 4: consecutive differing full-scan samples needed to flip a key. Range 1..7.
- `clk` input, 1 bit: 12 MHz system clock. All logic is on its rising edge.
- `resx` input, 1 bit: reset. **Synchronous, active-low.**
- `lcol` output, 4 bits: column select, active-low one-hot. Bit n drives column n.
- `krow` input, 8 bits: row sense, active-low (pulled up, pressed = 0). Asynchronous to `clk`.
- `key_valid` output, 1 bit: FIFO non-empty.
- `key_ready` input, 1 bit: consumer accepts the head event.
- `key_code` output, 6 bits: head event as {press, col[1:0], row[2:0]}.
- `key_state` output, 32 bits: debounced pressed bitmap. Bit index is col*8+row; 1 means pressed.
- `overflow` output, 1 bit: sticky, set when an event is dropped.

## Operation
- **Input sync:** `krow` passes through a 2-flop synchronizer, then is inverted to give `rows_s`, where 1 means pressed.
- **Slot timing:**
  - `div_cnt` counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps and `col` increments mod 4.
  - `lcol = ~(4'b0001 << col)`.
- **Sampling:** at `div_cnt == SCAN_DIV-1`, `rows_s` is latched into `samp[7:0]` and the current `col` is latched into `pcol`. This settles the sample late in the slot.
- **Processing:**
  - During `div_cnt` 0..7 of the following slot, one key per cycle is processed: row r = `div_cnt`, key index k = pcol*8+r.
  - If `samp[r] == key_state[k]`, then `dcnt[k]` is set to 0.
  - Otherwise `dcnt[k]` increments.
  - When the incremented value equals DEBOUNCE: `key_state[k]` toggles, `dcnt[k]` is set to 0, and an event {new state, pcol, r} is pushed.
- **FIFO:** 4 entries, first-word fall-through.
  - `key_code` is the head entry and is only meaningful while `key_valid` = 1.
  - A pop happens on `key_valid & key_ready`.
  - If a push and a pop occur in the same cycle while full, the push is accepted.
  - A push while full with no pop drops the event and sets `overflow`.
  - A pop while empty is ignored.
- **Arithmetic:** `dcnt` is 3 bits per key (32 × 3). `col` wraps 3→0. `div_cnt` is $clog2(SCAN_DIV) bits wide.
- **Reset:** when `resx` = 0 at a rising edge, every register returns to its reset value and any in-progress processing phase is abandoned. Scanning restarts at col 0, `div_cnt` 0. The first sample is taken at the end of slot 0.

## Timing
- **Reset values:**
  - `lcol` = 4'b1111 (no column driven).
  - `key_valid` = 0, `key_code` = 6'h00, `key_state` = 32'h0, `overflow` = 0.
  - All `dcnt` = 0, FIFO empty.
- **After reset release:** `lcol` = 4'b1110 from the first cycle.
- **Full scan period:** 4 × SCAN_DIV cycles. A key is sampled once per full scan.
- **Press-to-event latency:**
  - A stable press must be present in the synchronizer output at DEBOUNCE consecutive sample points of that key's column.
  - The event is pushed in cycle r of the slot after the last of those samples.
  - `key_valid` rises 1 cycle after the push.
  - `key_state` updates in the same cycle as the push.
- **Ordering:** within one column, events are pushed in ascending row order on consecutive cycles.
- **Handshake:** `key_code` is held stable while `key_valid` = 1 and `key_ready` = 0.

## Configuration
- `KEY_SCAN_RELEASE_EVT_EN`
  - **Defined:** both press (bit5 = 1) and release (bit5 = 0) events are pushed.
  - **Undefined:** only press events are pushed. Releases still update `key_state` and `dcnt` but never touch the FIFO or `overflow`.

## Test plan
- **Single press:** SCAN_DIV=16, DEBOUNCE=2, macro defined. Hold `krow[3]` = 0 only while `lcol` = 4'b1101, for 3 full scans. Required: one event `key_code` = 6'h2B, `key_state[11]` = 1, `lcol` walking 1110→1101→1011→0111.
- **Release:** from the single-press end state, release row 3 for 3 scans. Required: event 6'h0B, `key_state` = 0.
- **Bounce reject:** pulse the col-1 row-3 press for exactly 1 scan with DEBOUNCE=2. Required: no event, `key_state` unchanged, `dcnt` cleared on the next matching sample.
- **Overflow:** `key_ready` = 0, press 5 distinct keys in column 0, all held. Required:
  - 4 events queued in row order: 6'h20, 6'h21, 6'h22, 6'h23.
  - `overflow` = 1 and the fifth event (6'h24) dropped.
  - When the FIFO is later drained, `overflow` stays 1.
- **Full + simultaneous:** FIFO full, `key_ready` = 1 in the push cycle. Required: the new event is accepted, occupancy stays 4, `overflow` stays 0.
- **Reset and macro:**
  - Assert `resx` = 0 for 1 cycle mid-processing with a key held. Required: all outputs return to reset values, and the key re-reports after DEBOUNCE scans.
  - Macro undefined, full press/release cycle. Required: only the press event appears.
